// File: rtl/jk_reg_arbiter.sv
// ---------------------------------------------------------------------------
// jk_reg_arbiter
//
// Two requesters share a WIDTH-bit register made of JK flip-flops. Each
// request names one bit (idx) and a {J,K} command (00 hold, 01 clear,
// 10 set, 11 toggle). A three-state FSM (IDLE -> GRANT -> APPLY) serialises
// the requests: one command per three cycles.
//
// Optional build macro:
//   JK_ARB_FIXED_PRI_EN  defined   : requester 0 always wins a tie, no pointer
//                        undefined : round-robin between the two requesters
//
// Ports:
//   clk          sole clock, rising edge
//   clr          asynchronous active-high reset
//   req0/req1    request, held high until the matching ack
//   idx0/idx1    target bit, captured when the winner is chosen
//   jk0/jk1      {J,K} command, captured when the winner is chosen
//   gnt0/gnt1    one-cycle grant pulse (GRANT state)
//   ack0/ack1    one-cycle completion pulse (APPLY state, q already updated)
//   q            shared register contents
//   busy         high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module jk_reg_arbiter #(
    parameter int WIDTH = 4,
    parameter int IDXW  = 2
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             req0,
    input  logic             req1,
    input  logic [IDXW-1:0]  idx0,
    input  logic [IDXW-1:0]  idx1,
    input  logic [1:0]       jk0,
    input  logic [1:0]       jk1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] q,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        APPLY = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              win;        // requester owning the command in flight
    logic              win_nxt;
    logic [IDXW-1:0]   lat_idx;
    logic [1:0]        lat_jk;
    logic [WIDTH-1:0]  q_upd;

    // -----------------------------------------------------------------------
    // Winner selection
    // -----------------------------------------------------------------------
`ifdef JK_ARB_FIXED_PRI_EN
    always_comb begin
        win_nxt = 1'b0;
        if (!req0 && req1)
            win_nxt = 1'b1;
    end
`else
    // ptr names the requester that wins the next tie; it points away from
    // whoever completed last, so reset value 0 favours requester 0.
    logic ptr;

    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            ptr <= 1'b0;
        else if (state == APPLY)
            ptr <= ~win;
    end

    always_comb begin
        win_nxt = 1'b0;
        if (req0 && req1)
            win_nxt = ptr;
        else if (req1)
            win_nxt = 1'b1;
    end
`endif

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req0 || req1) state_nxt = GRANT;
            GRANT:   state_nxt = APPLY;
            APPLY:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        gnt0 = (state == GRANT) && !win;
        gnt1 = (state == GRANT) &&  win;
        ack0 = (state == APPLY) && !win;
        ack1 = (state == APPLY) &&  win;
        busy = (state != IDLE);
    end

    // -----------------------------------------------------------------------
    // Command capture and register update
    // -----------------------------------------------------------------------
    // Only the addressed bit can change; an idx beyond WIDTH matches no bit.
    always_comb begin
        q_upd = q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (lat_idx == IDXW'(i)) begin
                case (lat_jk)
                    2'b01:   q_upd[i] = 1'b0;
                    2'b10:   q_upd[i] = 1'b1;
                    2'b11:   q_upd[i] = ~q[i];
                    default: q_upd[i] = q[i];
                endcase
            end
        end
    end

    // The command is captured on the edge that enters GRANT, so later idx/jk
    // changes cannot reach it. q is written on the edge that enters APPLY,
    // which makes the result visible together with the ack pulse.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            win     <= 1'b0;
            lat_idx <= '0;
            lat_jk  <= '0;
            q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        win     <= win_nxt;
                        lat_idx <= win_nxt ? idx1 : idx0;
                        lat_jk  <= win_nxt ? jk1  : jk0;
                    end
                end
                GRANT:   q <= q_upd;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jk_reg_arbiter.sv
// ---------------------------------------------------------------------------
// tb_jk_reg_arbiter
//
// Scoreboard bench for jk_reg_arbiter (WIDTH=4, IDXW=3 so that out-of-range
// indices can be issued). Stimulus pushes the expected grant/ack events with
// their cycle and resulting q into a queue; an independent monitor pops and
// compares whenever the DUT shows a gnt or ack. The monitor also checks that
// handshakes are one-hot-or-zero and that busy tracks GRANT/APPLY.
// ---------------------------------------------------------------------------
module tb_jk_reg_arbiter;

    logic       clk;
    logic       clr;
    logic       req0, req1;
    logic [2:0] idx0, idx1;
    logic [1:0] jk0, jk1;
    logic       gnt0, gnt1, ack0, ack1;
    logic [3:0] q;
    logic       busy;

    jk_reg_arbiter #(.WIDTH(4), .IDXW(3)) dut (
        .clk  (clk),
        .clr  (clr),
        .req0 (req0),
        .req1 (req1),
        .idx0 (idx0),
        .idx1 (idx1),
        .jk0  (jk0),
        .jk1  (jk1),
        .gnt0 (gnt0),
        .gnt1 (gnt1),
        .ack0 (ack0),
        .ack1 (ack1),
        .q    (q),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_ack;
        bit         who;
        logic [3:0] qv;
        int         at;
    } exp_t;

    exp_t sbq[$];
    bit   sb_en = 1'b1;
    int   total = 0;
    int   passed = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req)
            passed++;
        else
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    endtask

    task automatic push_exp(input bit is_ack, input bit who, input logic [3:0] qv, input int at);
        exp_t e;
        e.is_ack = is_ack;
        e.who    = who;
        e.qv     = qv;
        e.at     = at;
        sbq.push_back(e);
    endtask

    // Monitor: property checks every cycle, scoreboard on every handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!clr) begin
            check("onehot", {31'd0, ($countones({gnt0, gnt1, ack0, ack1}) <= 1)}, 1);
            check("busy_state", busy, gnt0 | gnt1 | ack0 | ack1);
            if (sb_en && (gnt0 || gnt1 || ack0 || ack1)) begin
                if (sbq.size() == 0) begin
                    check("unexpected_evt", {gnt0, gnt1, ack0, ack1}, 0);
                end else begin
                    e = sbq.pop_front();
                    check("evt_kind", ack0 | ack1, e.is_ack);
                    check(e.is_ack ? "ack_who" : "gnt_who", e.is_ack ? ack1 : gnt1, e.who);
                    check(e.is_ack ? "ack_cycle" : "gnt_cycle", cyc, e.at);
                    if (e.is_ack)
                        check("ack_q", q, e.qv);
                end
            end
        end
    end

    task automatic drive(input bit who, input logic r, input logic [2:0] i, input logic [1:0] j);
        if (who) begin
            req1 = r; idx1 = i; jk1 = j;
        end else begin
            req0 = r; idx0 = i; jk0 = j;
        end
    endtask

    // Bounded wait for a gnt (is_ack=0) or ack (is_ack=1) of one requester.
    task automatic wait_evt(input bit is_ack, input bit who, input string nm);
        bit seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (is_ack ? (who ? ack1 : ack0) : (who ? gnt1 : gnt0))
                seen = 1'b1;
        end
        if (!seen)
            check(nm, 0, 1);
    endtask

    // One command from IDLE; returns at the negedge of the following IDLE cycle.
    task automatic cmd(input bit who, input logic [2:0] i, input logic [1:0] j,
                       input logic [3:0] qexp, input bit alter);
        push_exp(1'b0, who, 4'h0, cyc + 1);
        push_exp(1'b1, who, qexp, cyc + 2);
        drive(who, 1'b1, i, j);
        if (alter) begin
            wait_evt(1'b0, who, "gnt_timeout");
            drive(who, 1'b1, 3'd0, 2'b10);
        end
        wait_evt(1'b1, who, "ack_timeout");
        drive(who, 1'b0, 3'd0, 2'b00);
        @(negedge clk);
    endtask

    task automatic do_reset();
        clr = 1'b1;
        #1;
        check("rst_q", q, 0);
        check("rst_busy", busy, 0);
        check("rst_hs", {gnt0, gnt1, ack0, ack1}, 0);
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
    endtask

    logic [3:0] dual_q [4];
    bit         dual_w [4];

    initial begin
        int base;
        int acks;

        req0 = 1'b0; req1 = 1'b0;
        idx0 = '0;   idx1 = '0;
        jk0  = '0;   jk1  = '0;
        clr  = 1'b1;
        repeat (2) @(negedge clk);
        do_reset();

        // set bit 2 from reset
        cmd(1'b0, 3'd2, 2'b10, 4'b0100, 1'b0);

        // req1 held through its ack: toggle bit 2 twice, back to back
        push_exp(1'b0, 1'b1, 4'h0,    cyc + 1);
        push_exp(1'b1, 1'b1, 4'b0000, cyc + 2);
        push_exp(1'b0, 1'b1, 4'h0,    cyc + 4);
        push_exp(1'b1, 1'b1, 4'b0100, cyc + 5);
        drive(1'b1, 1'b1, 3'd2, 2'b11);
        wait_evt(1'b1, 1'b1, "ack_timeout");
        wait_evt(1'b1, 1'b1, "ack_timeout");
        drive(1'b1, 1'b0, 3'd0, 2'b00);
        @(negedge clk);

        // set bit 3, then clear it while idx/jk change after the grant
        cmd(1'b0, 3'd3, 2'b10, 4'b1100, 1'b0);
        cmd(1'b0, 3'd3, 2'b01, 4'b0100, 1'b1);
        // hold on bit 1, then out-of-range indices
        cmd(1'b1, 3'd1, 2'b00, 4'b0100, 1'b0);
        cmd(1'b1, 3'd5, 2'b11, 4'b0100, 1'b0);
        cmd(1'b0, 3'd7, 2'b10, 4'b0100, 1'b0);
        check("sb_drain", sbq.size(), 0);

        // clr while in APPLY aborts the command
        do_reset();
        push_exp(1'b0, 1'b0, 4'h0, cyc + 1);
        drive(1'b0, 1'b1, 3'd1, 2'b10);
        wait_evt(1'b0, 1'b0, "gnt_timeout");
        @(posedge clk);
        #1 clr = 1'b1;
        #1;
        check("abort_q", q, 0);
        check("abort_busy", busy, 0);
        check("abort_ack", ack0, 0);
        drive(1'b0, 1'b0, 3'd0, 2'b00);
        @(negedge clk);
        clr = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_q_after", q, 0);
        check("sb_drain_abort", sbq.size(), 0);

        // both requesters held for four commands
        do_reset();
`ifdef JK_ARB_FIXED_PRI_EN
        dual_w = '{1'b0, 1'b0, 1'b0, 1'b0};
        dual_q = '{4'b0001, 4'b0000, 4'b0001, 4'b0000};
`else
        dual_w = '{1'b0, 1'b1, 1'b0, 1'b1};
        dual_q = '{4'b0001, 4'b0011, 4'b0010, 4'b0000};
`endif
        base = cyc;
        for (int k = 0; k < 4; k++) begin
            push_exp(1'b0, dual_w[k], 4'h0,      base + 1 + 3 * k);
            push_exp(1'b1, dual_w[k], dual_q[k], base + 2 + 3 * k);
        end
        drive(1'b0, 1'b1, 3'd0, 2'b11);
        drive(1'b1, 1'b1, 3'd1, 2'b11);
        acks = 0;
        for (int n = 0; n < 40 && acks < 4; n++) begin
            @(negedge clk);
            if (ack0 || ack1)
                acks++;
        end
        check("dual_acks", acks, 4);
        drive(1'b0, 1'b0, 3'd0, 2'b00);
        drive(1'b1, 1'b0, 3'd0, 2'b00);
        repeat (2) @(negedge clk);
        check("sb_drain_dual", sbq.size(), 0);

        // random traffic: protocol and exclusivity only
        sb_en = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (gnt0) check("gnt0_req", req0, 1);
            if (gnt1) check("gnt1_req", req1, 1);
            if (req0 && ack0)
                drive(1'b0, 1'b0, 3'd0, 2'b00);
            else if (!req0 && $urandom_range(0, 3) == 0)
                drive(1'b0, 1'b1, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
            if (req1 && ack1)
                drive(1'b1, 1'b0, 3'd0, 2'b00);
            else if (!req1 && $urandom_range(0, 3) == 0)
                drive(1'b1, 1'b1, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
        end
        drive(1'b0, 1'b0, 3'd0, 2'b00);
        drive(1'b1, 1'b0, 3'd0, 2'b00);
        repeat (4) @(negedge clk);
        check("idle_end", busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
